// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the filter-processor pipeline
// hazard controller.
//   state_t          - controller FSM state (RUN, MEM_WAIT)
//   FWD_RF/MEM/WB    - EX operand-forwarding select codes
//   REG_W            - register-index width (16 architectural registers)
package pipe_ctrl_pkg;

    localparam int REG_W = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/haz_fwd_unit.sv
// haz_fwd_unit: combinational register-index comparisons for the hazard
// controller. Produces the ID-stage hazard hit and the EX operand-forward
// selects; no state.
// Build option: HAZ_FORWARD_EN
//   defined   - haz is the load-use hit, fwd_a/fwd_b select MEM/WB bypasses
//   undefined - haz is a full RAW hit against EX/MEM/WB, fwd_a/fwd_b are 0
// Ports:
//   id_rs1/2, id_use1/2       : ID sources and their use flags
//   ex_rs1/2                  : EX sources
//   ex_rg/mem_rg/wb_rg, *_we  : per-stage destination and write flag
//   ex_is_load, mem_is_load   : stage result comes from data memory
//   haz                       : ID instruction must stall one cycle
//   fwd_a, fwd_b              : EX operand source selects
module haz_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rg,
    input  logic [REG_W-1:0] mem_rg,
    input  logic [REG_W-1:0] wb_rg,
    input  logic             ex_we,
    input  logic             mem_we,
    input  logic             wb_we,
    input  logic             ex_is_load,
    input  logic             mem_is_load,
    output logic             haz,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    localparam int NUM_SRC = 2;

    logic [NUM_SRC-1:0][REG_W-1:0] id_src;
    logic [NUM_SRC-1:0][REG_W-1:0] ex_src;
    logic [NUM_SRC-1:0]            id_use;
    logic [NUM_SRC-1:0]            src_hit;
    logic [NUM_SRC-1:0][1:0]       fwd;

    assign id_src = {id_rs2, id_rs1};
    assign ex_src = {ex_rs2, ex_rs1};
    assign id_use = {id_use2, id_use1};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
`ifdef HAZ_FORWARD_EN
        // Only a load in EX cannot be bypassed in time; everything else forwards.
        assign src_hit[i] = id_use[i] & ex_is_load & ex_we & (ex_rg == id_src[i]);
        // A load result sitting in MEM is not yet available on the ALU bypass.
        assign fwd[i] = (mem_we && !mem_is_load && (mem_rg == ex_src[i])) ? FWD_MEM :
                        (wb_we  && (wb_rg == ex_src[i]))                   ? FWD_WB  :
                                                                             FWD_RF;
`else
        assign src_hit[i] = id_use[i] & ((ex_we  & (ex_rg  == id_src[i])) |
                                         (mem_we & (mem_rg == id_src[i])) |
                                         (wb_we  & (wb_rg  == id_src[i])));
        assign fwd[i]     = FWD_RF;
`endif
    end

    assign haz   = |src_hit;
    assign fwd_a = fwd[0];
    assign fwd_b = fwd[1];

`ifndef HAZ_FORWARD_EN
    // Without bypassing these inputs carry no information for this unit.
    logic unused_nofwd;
    assign unused_nofwd = ^{ex_src, ex_is_load, mem_is_load};
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall controller for the 5-stage filter pipeline.
// Per cycle decides load/hold/bubble for IF/ID, ID/EX, EX/MEM and MEM/WB,
// drives EX forwarding selects and waits on the data-memory handshake with a
// timeout. All control outputs are Mealy (same-cycle).
// Build option: HAZ_FORWARD_EN (see haz_fwd_unit) selects load-use+forwarding
// versus full RAW stalling with forwarding disabled.
// Parameters: MEM_TIMEOUT (>=2) stalled cycles before forced release,
//             CNT_W width of the saturating stall counter.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   id_*/ex_*/mem_*/wb_*           : stage register indices and flags
//   branch_taken                   : EX resolved a taken branch
//   mem_req, mem_ack               : data-memory handshake
//   *_en, *_bubble                 : pipeline register load / kill controls
//   fwd_a, fwd_b                   : EX operand sources
//   mem_err                        : sticky memory-timeout flag
//   stall_cnt                      : cycles with pc_en low, saturating
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rg,
    input  logic [REG_W-1:0] mem_rg,
    input  logic [REG_W-1:0] wb_rg,
    input  logic             ex_we,
    input  logic             mem_we,
    input  logic             wb_we,
    input  logic             ex_is_load,
    input  logic             mem_is_load,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_bubble,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              mem_stall;
    logic              haz;
    logic [1:0]        fwd_a_cmp, fwd_b_cmp;

    haz_fwd_unit u_cmp (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use1     (id_use1),
        .id_use2     (id_use2),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rg       (ex_rg),
        .mem_rg      (mem_rg),
        .wb_rg       (wb_rg),
        .ex_we       (ex_we),
        .mem_we      (mem_we),
        .wb_we       (wb_we),
        .ex_is_load  (ex_is_load),
        .mem_is_load (mem_is_load),
        .haz         (haz),
        .fwd_a       (fwd_a_cmp),
        .fwd_b       (fwd_b_cmp)
    );

    // The RUN cycle that enters MEM_WAIT is stall #1, so MEM_WAIT cycles with
    // wait_cnt 0..MEM_TIMEOUT-2 complete MEM_TIMEOUT stalls and the cycle at
    // MEM_TIMEOUT-1 is the forced release, treated like an ack cycle.
    assign timeout = (state == MEM_WAIT) && !mem_ack && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_nxt = MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack || timeout) state_nxt = RUN;
                else                    mem_stall = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == MEM_WAIT && state_nxt == MEM_WAIT) ? wait_cnt + 1'b1 : '0;
            if (timeout) mem_err <= 1'b1;
            if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_bubble  = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        fwd_a         = fwd_a_cmp;
        fwd_b         = fwd_b_cmp;
        if (!rst_n) begin
            // Flush: every register loads a killed entry.
            if_id_bubble  = 1'b1;
            id_ex_bubble  = 1'b1;
            mem_wb_bubble = 1'b1;
            fwd_a         = FWD_RF;
            fwd_b         = FWD_RF;
        end else if (mem_stall) begin
            // Freeze the pipe; WB must not retire the held MEM result twice.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_bubble  = 1'b1;
            id_ex_bubble  = 1'b1;
        end else if (haz) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_bubble  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Expected control vectors are queued when a cycle's inputs are driven and
// popped for comparison mid-cycle, away from the rising edge.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //  if_id_bubble, id_ex_bubble, mem_wb_bubble, fwd_a, fwd_b}
    localparam logic [11:0] NORM  = 12'b11111_000_00_00;
    localparam logic [11:0] RST   = 12'b11111_111_00_00;
    localparam logic [11:0] MEMST = 12'b00001_001_00_00;
    localparam logic [11:0] BR    = 12'b11111_110_00_00;
    localparam logic [11:0] HAZ   = 12'b00111_010_00_00;

    typedef struct {
        string            tag;
        logic [11:0]      ctl;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk, rst_n;
    logic [3:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rg, mem_rg, wb_rg;
    logic id_use1, id_use2, ex_we, mem_we, wb_we, ex_is_load, mem_is_load;
    logic branch_taken, mem_req, mem_ack;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_bubble, id_ex_bubble, mem_wb_bubble, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic exp_err = 1'b0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rg(ex_rg), .mem_rg(mem_rg), .wb_rg(wb_rg),
        .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
        .mem_wb_bubble(mem_wb_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input logic [11:0] b, input logic [1:0] fa,
                                       input logic [1:0] fb);
        return {b[11:4], fa, fb};
    endfunction

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rg = 0; mem_rg = 0; wb_rg = 0;
        ex_we = 0; mem_we = 0; wb_we = 0; ex_is_load = 0; mem_is_load = 0;
        branch_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Load in EX writing r5 while ID reads r5 as rs2.
    task automatic ldu();
        ex_is_load = 1; ex_we = 1; ex_rg = 5; id_use2 = 1; id_rs2 = 5;
    endtask

    task automatic chk(input string tag, input logic [11:0] ctl);
        exp_t e;
        exp_t o;
        logic [11:0] got;
        e.tag = tag; e.ctl = ctl; e.err = exp_err; e.cnt = exp_stall;
        sb.push_back(e);
        #2;
        o = sb.pop_front();
        got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_bubble, id_ex_bubble, mem_wb_bubble, fwd_a, fwd_b};
        checks++;
        assert (got === o.ctl) else begin
            errors++;
            $error("FAIL %s ctl got=%b exp=%b", o.tag, got, o.ctl);
        end
        checks++;
        assert (mem_err === o.err) else begin
            errors++;
            $error("FAIL %s mem_err got=%b exp=%b", o.tag, mem_err, o.err);
        end
        checks++;
        assert (stall_cnt === o.cnt) else begin
            errors++;
            $error("FAIL %s stall_cnt got=%0d exp=%0d", o.tag, stall_cnt, o.cnt);
        end
        // Reference model for the registered state updated at the coming edge.
        if (!rst_n) begin
            exp_stall = '0;
            exp_err   = 1'b0;
        end else if (!ctl[11] && exp_stall != '1) begin
            exp_stall = exp_stall + 1'b1;
        end
    endtask

    initial begin
        rst_n = 0; clr();
        cyc(); chk("reset", RST);
        cyc(); mem_req = 1; branch_taken = 1; ldu(); chk("reset_busy", RST);
        cyc(); rst_n = 1; clr(); chk("run", NORM);

`ifdef HAZ_FORWARD_EN
        cyc(); clr(); mem_we = 1; mem_rg = 3; ex_rs1 = 3; chk("fwd_mem", mk(NORM, 1, 0));
        cyc(); clr(); wb_we = 1; wb_rg = 3; ex_rs1 = 3; chk("fwd_wb", mk(NORM, 2, 0));
        cyc(); clr(); mem_we = 1; mem_rg = 3; wb_we = 1; wb_rg = 3; ex_rs1 = 3; ex_rs2 = 3;
        chk("fwd_both", mk(NORM, 1, 1));
        cyc(); clr(); mem_we = 1; mem_is_load = 1; mem_rg = 7; wb_we = 1; wb_rg = 7; ex_rs2 = 7;
        chk("fwd_memload", mk(NORM, 0, 2));
        cyc(); clr(); wb_we = 1; wb_rg = 0; ex_rs1 = 0; ex_rs2 = 15; chk("fwd_r0", mk(NORM, 2, 0));
        cyc(); clr(); ldu(); chk("ldu_stall", HAZ);
        cyc(); clr(); mem_we = 1; mem_is_load = 1; mem_rg = 5; id_use2 = 1; id_rs2 = 5;
        chk("ldu_bubble", NORM);
        cyc(); clr(); wb_we = 1; wb_rg = 5; ex_rs2 = 5; chk("ldu_fwd", mk(NORM, 0, 2));
        cyc(); clr(); ex_we = 1; ex_rg = 4; id_use1 = 1; id_rs1 = 4; chk("alu_nostall", NORM);
`else
        cyc(); clr(); ex_we = 1; ex_rg = 2; id_use1 = 1; id_rs1 = 2; chk("raw_ex", HAZ);
        cyc(); clr(); mem_we = 1; mem_rg = 2; id_use1 = 1; id_rs1 = 2; ex_rs1 = 2; chk("raw_mem", HAZ);
        cyc(); clr(); wb_we = 1; wb_rg = 2; id_use1 = 1; id_rs1 = 2; ex_rs1 = 2; chk("raw_wb", HAZ);
        cyc(); clr(); id_use1 = 1; id_rs1 = 2; chk("raw_done", NORM);
        cyc(); clr(); ex_we = 1; ex_rg = 2; id_rs1 = 2; id_use2 = 1; id_rs2 = 9; chk("raw_unused", NORM);
        cyc(); clr(); wb_we = 1; wb_rg = 0; id_use2 = 1; id_rs2 = 0; chk("raw_r0", HAZ);
        cyc(); clr(); ldu(); chk("ldu_stall", HAZ);
`endif
        cyc(); clr(); ldu(); branch_taken = 1; chk("br_ldu", BR);

        for (int i = 0; i < 3; i++) begin
            cyc(); clr(); mem_req = 1; chk("mem_wait", MEMST);
        end
        cyc(); clr(); mem_req = 1; mem_ack = 1; chk("mem_ack", NORM);
        cyc(); clr(); chk("mem_after", NORM);
        cyc(); clr(); mem_req = 1; mem_ack = 1; chk("mem_fast", NORM);

        cyc(); clr(); mem_req = 1; branch_taken = 1; chk("br_in_wait", MEMST);
        cyc(); clr(); mem_req = 1; mem_ack = 1; branch_taken = 1; chk("br_release", BR);

        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            cyc(); clr(); mem_req = 1; chk("to_wait", MEMST);
        end
        cyc(); clr(); mem_req = 1; chk("to_release", NORM);
        exp_err = 1'b1;
        cyc(); clr(); chk("to_after", NORM);
        cyc(); clr(); chk("err_sticky", NORM);

        cyc(); clr(); mem_req = 1; chk("abort_w0", MEMST);
        cyc(); clr(); mem_req = 1; chk("abort_w1", MEMST);
        cyc(); rst_n = 0; clr(); mem_req = 1; chk("abort_rst", RST);
        cyc(); rst_n = 1; clr(); chk("abort_run", NORM);

        for (int i = 0; i < 18; i++) begin
            cyc(); clr(); ldu(); chk("sat", HAZ);
        end
        cyc(); clr(); chk("sat_end", NORM);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
